// File: rtl/be8_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// be8_sequencer_pkg
// Shared constants for the 8-bit bus CPU microstep controller:
//   - opcode values OP_NOP..OP_HLT
//   - BUS_SEL driver encodings
//   - T-state constants
//   - control-word layout produced by the microcode decoder
// ----------------------------------------------------------------------------
package be8_sequencer_pkg;

    // Opcodes (IR[7:4])
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Bus driver select
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_RAM  = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd3;
    localparam logic [2:0] BUS_A    = 3'd4;
    localparam logic [2:0] BUS_ALU  = 3'd5;

    // T-states
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word: strobes are active-high here; the top level inverts the
    // LOADn ones and gates everything with reset/halt/step-enable.
    typedef struct packed {
        logic       mi;         // MAR load
        logic       ri;         // RAM write
        logic       ii;         // IR load
        logic       ai;         // A load
        logic       bi;         // B load
        logic       oi;         // OUT load
        logic       fi;         // FLAGS load
        logic       j;          // PC jump load
        logic       ce;         // PC count enable
        logic       su;         // ALU subtract
        logic [2:0] bus_sel;    // bus driver
        logic       last_step;  // next T-state is T0
        logic       halt;       // set HALTED at the end of this step
    } ctrl_word_t;

    localparam ctrl_word_t CW_EMPTY = 15'd0;

    // Opcodes 9..13 have no defined instruction.
    function automatic logic is_undef(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd13);
    endfunction

endpackage

// File: rtl/be8_sequencer_if.sv
// ----------------------------------------------------------------------------
// be8_sequencer_if
// Control/status bundle between the sequencer and the rest of the CPU.
//   master : the sequencer (consumes STEP_EN/IR_OP/flags, drives strobes)
//   slave  : the datapath side (drives STEP_EN/IR_OP/flags, consumes strobes)
// ----------------------------------------------------------------------------
interface be8_sequencer_if;
    logic       STEP_EN;
    logic [3:0] IR_OP;
    logic       FLAG_C;
    logic       FLAG_Z;
    logic       MAR_LOADn;
    logic       RAM_LOADn;
    logic       IR_LOADn;
    logic       A_LOADn;
    logic       B_LOADn;
    logic       OUT_LOADn;
    logic       FLAGS_LOADn;
    logic       PC_LOADn;
    logic       PC_INC;
    logic       ALU_SUB;
    logic [2:0] BUS_SEL;
    logic [2:0] TSTATE;
    logic       HALTED;

    modport master (
        input  STEP_EN, IR_OP, FLAG_C, FLAG_Z,
        output MAR_LOADn, RAM_LOADn, IR_LOADn, A_LOADn, B_LOADn, OUT_LOADn,
               FLAGS_LOADn, PC_LOADn, PC_INC, ALU_SUB, BUS_SEL, TSTATE, HALTED
    );

    modport slave (
        output STEP_EN, IR_OP, FLAG_C, FLAG_Z,
        input  MAR_LOADn, RAM_LOADn, IR_LOADn, A_LOADn, B_LOADn, OUT_LOADn,
               FLAGS_LOADn, PC_LOADn, PC_INC, ALU_SUB, BUS_SEL, TSTATE, HALTED
    );
endinterface

// File: rtl/be8_sequencer_microcode.sv
// ----------------------------------------------------------------------------
// be8_sequencer_microcode
// Purely combinational microcode decoder.
// Ports:
//   ir_op   in  4  opcode nibble
//   tstate  in  3  current T-state
//   flag_c  in  1  carry flag (used by JC in T2)
//   flag_z  in  1  zero flag (used by JZ in T2)
//   cw      out    control word {strobes, bus_sel, last_step, halt}
// Parameter HALT_ON_UNDEF: 1 makes opcodes 9-13 act as HLT, 0 as NOP.
// ----------------------------------------------------------------------------
module be8_sequencer_microcode
    import be8_sequencer_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic [3:0] ir_op,
    input  logic [2:0] tstate,
    input  logic       flag_c,
    input  logic       flag_z,
    output ctrl_word_t cw
);

    // Map {opcode, T-state, flags} to one control word.
    always_comb begin
        cw = CW_EMPTY;
        case (tstate)
            T0: begin
                cw.mi      = 1'b1;
                cw.bus_sel = BUS_PC;
            end
            T1: begin
                cw.ii      = 1'b1;
                cw.ce      = 1'b1;
                cw.bus_sel = BUS_RAM;
            end
            T2: begin
                // Most instructions finish here; multi-step ones clear it.
                cw.last_step = 1'b1;
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.mi        = 1'b1;
                        cw.bus_sel   = BUS_IR;
                        cw.last_step = 1'b0;
                    end
                    OP_LDI: begin
                        cw.ai      = 1'b1;
                        cw.bus_sel = BUS_IR;
                    end
                    OP_JMP: begin
                        cw.j       = 1'b1;
                        cw.bus_sel = BUS_IR;
                    end
                    OP_JC: begin
                        if (flag_c) begin
                            cw.j       = 1'b1;
                            cw.bus_sel = BUS_IR;
                        end else begin
                            cw.j       = 1'b0;
                        end
                    end
                    OP_JZ: begin
                        if (flag_z) begin
                            cw.j       = 1'b1;
                            cw.bus_sel = BUS_IR;
                        end else begin
                            cw.j       = 1'b0;
                        end
                    end
                    OP_OUT: begin
                        cw.oi      = 1'b1;
                        cw.bus_sel = BUS_A;
                    end
                    OP_HLT: begin
                        cw.halt = 1'b1;
                    end
                    default: begin
                        // NOP and the undefined opcodes: empty step.
                        if (HALT_ON_UNDEF && is_undef(ir_op)) begin
                            cw.halt = 1'b1;
                        end else begin
                            cw.halt = 1'b0;
                        end
                    end
                endcase
            end
            T3: begin
                cw.last_step = 1'b1;
                case (ir_op)
                    OP_LDA: begin
                        cw.ai      = 1'b1;
                        cw.bus_sel = BUS_RAM;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.bi        = 1'b1;
                        cw.bus_sel   = BUS_RAM;
                        cw.last_step = 1'b0;
                    end
                    OP_STA: begin
                        cw.ri      = 1'b1;
                        cw.bus_sel = BUS_A;
                    end
                    default: begin
                        cw.last_step = 1'b1;
                    end
                endcase
            end
            T4: begin
                cw.last_step = 1'b1;
                case (ir_op)
                    OP_ADD, OP_SUB: begin
                        cw.ai      = 1'b1;
                        cw.fi      = 1'b1;
                        cw.su      = (ir_op == OP_SUB);
                        cw.bus_sel = BUS_ALU;
                    end
                    default: begin
                        cw.last_step = 1'b1;
                    end
                endcase
            end
            default: begin
                // T5..T7 are unreachable; recover to T0.
                cw.last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/be8_sequencer.sv
// ----------------------------------------------------------------------------
// be8_sequencer
// Microstep controller for the 8-bit bus CPU: steps T0..T4, decodes the IR
// opcode and C/Z flags into active-low load strobes plus a bus-source select.
// Ports:
//   CLK    in  1  clock, all state on posedge
//   RESET  in  1  synchronous, active-high
//   bus    be8_sequencer_if.master
//          in : STEP_EN, IR_OP, FLAG_C, FLAG_Z
//          out: *_LOADn strobes, PC_INC, ALU_SUB, BUS_SEL, TSTATE, HALTED
// Strobes are combinational from registered TSTATE/HALTED so the target
// registers capture on the same edge that advances TSTATE.
// ----------------------------------------------------------------------------
module be8_sequencer
    import be8_sequencer_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    be8_sequencer_if.master   bus
);

    logic [2:0] tstate_r;
    logic       halted_r;
    ctrl_word_t cw_s;
    logic       active_s;
    logic       drive_s;

    be8_sequencer_microcode #(
        .HALT_ON_UNDEF (HALT_ON_UNDEF)
    ) u_microcode (
        .ir_op  (bus.IR_OP),
        .tstate (tstate_r),
        .flag_c (bus.FLAG_C),
        .flag_z (bus.FLAG_Z),
        .cw     (cw_s)
    );

    // Gating: strobes need a running, non-halted, non-reset step; the bus
    // select survives a STEP_EN pause but not reset or halt.
    always_comb begin
        drive_s  = ~RESET & ~halted_r;
        active_s = drive_s & bus.STEP_EN;
    end

    // Output decode.
    always_comb begin
        bus.MAR_LOADn   = ~(cw_s.mi & active_s);
        bus.RAM_LOADn   = ~(cw_s.ri & active_s);
        bus.IR_LOADn    = ~(cw_s.ii & active_s);
        bus.A_LOADn     = ~(cw_s.ai & active_s);
        bus.B_LOADn     = ~(cw_s.bi & active_s);
        bus.OUT_LOADn   = ~(cw_s.oi & active_s);
        bus.FLAGS_LOADn = ~(cw_s.fi & active_s);
        bus.PC_LOADn    = ~(cw_s.j  & active_s);
        bus.PC_INC      = cw_s.ce & active_s;
        bus.ALU_SUB     = cw_s.su & active_s;
        bus.BUS_SEL     = drive_s ? cw_s.bus_sel : BUS_NONE;
        bus.TSTATE      = tstate_r;
        bus.HALTED      = halted_r;
    end

    // T-state / halt state machine.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tstate_r <= T0;
            halted_r <= 1'b0;
        end else if (halted_r) begin
            tstate_r <= tstate_r;
            halted_r <= halted_r;
        end else if (bus.STEP_EN) begin
            if (cw_s.halt) begin
                tstate_r <= T0;
                halted_r <= 1'b1;
            end else if (cw_s.last_step) begin
                tstate_r <= T0;
                halted_r <= 1'b0;
            end else begin
                tstate_r <= tstate_r + 3'd1;
                halted_r <= 1'b0;
            end
        end else begin
            tstate_r <= tstate_r;
            halted_r <= halted_r;
        end
    end

endmodule

// File: tb/tb_be8_sequencer.sv
// ----------------------------------------------------------------------------
// tb_be8_sequencer
// Self-checking bench for be8_sequencer: a per-instruction vector table,
// hand-written halt/pause/reset sequences, and a randomized run compared
// against a step-list reference model.
// ----------------------------------------------------------------------------
module tb_be8_sequencer;

    logic CLK;
    logic RESET;
    be8_sequencer_if bus_if ();

    be8_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe masks (active-high view): mi ri ii ai bi oi fi j ce su
    localparam logic [9:0] S_MI = 10'b1000000000;
    localparam logic [9:0] S_RI = 10'b0100000000;
    localparam logic [9:0] S_II = 10'b0010000000;
    localparam logic [9:0] S_AI = 10'b0001000000;
    localparam logic [9:0] S_BI = 10'b0000100000;
    localparam logic [9:0] S_OI = 10'b0000010000;
    localparam logic [9:0] S_FI = 10'b0000001000;
    localparam logic [9:0] S_J  = 10'b0000000100;
    localparam logic [9:0] S_CE = 10'b0000000010;
    localparam logic [9:0] S_SU = 10'b0000000001;
    localparam logic [12:0] IDLE = 13'b1111_1111_00_000;

    int checks = 0;
    int errors = 0;

    logic [12:0] obs;
    assign obs = {bus_if.MAR_LOADn, bus_if.RAM_LOADn, bus_if.IR_LOADn, bus_if.A_LOADn,
                  bus_if.B_LOADn, bus_if.OUT_LOADn, bus_if.FLAGS_LOADn, bus_if.PC_LOADn,
                  bus_if.PC_INC, bus_if.ALU_SUB, bus_if.BUS_SEL};

    // Observable word for a set of active strobes and a bus source.
    function automatic logic [12:0] w(input logic [9:0] s, input logic [2:0] b);
        return {~s[9:2], s[1:0], b};
    endfunction

    // Reference model: the word emitted at step 'pos' of an instruction
    // (0,1 = fetch; 2.. = execute).
    function automatic logic [12:0] mword(input logic [3:0] op, input logic c, input logic z,
                                          input int pos);
        logic [12:0] r;
        r = IDLE;
        if (pos == 0) r = w(S_MI, 3'd1);
        else if (pos == 1) r = w(S_II | S_CE, 3'd2);
        else if (pos == 2) begin
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4: r = w(S_MI, 3'd3);
                4'd5:  r = w(S_AI, 3'd3);
                4'd6:  r = w(S_J, 3'd3);
                4'd7:  r = c ? w(S_J, 3'd3) : IDLE;
                4'd8:  r = z ? w(S_J, 3'd3) : IDLE;
                4'd14: r = w(S_OI, 3'd4);
                default: r = IDLE;
            endcase
        end else if (pos == 3) begin
            case (op)
                4'd1:       r = w(S_AI, 3'd2);
                4'd2, 4'd3: r = w(S_BI, 3'd2);
                4'd4:       r = w(S_RI, 3'd4);
                default:    r = IDLE;
            endcase
        end else if (pos == 4) begin
            r = (op == 4'd3) ? w(S_AI | S_FI | S_SU, 3'd5) : w(S_AI | S_FI, 3'd5);
        end else begin
            r = IDLE;
        end
        return r;
    endfunction

    // Total number of T-states an instruction occupies.
    function automatic int mlen(input logic [3:0] op);
        case (op)
            4'd1, 4'd4: return 4;
            4'd2, 4'd3: return 5;
            default:    return 3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge; return at the following falling edge.
    task automatic drive(input logic rst, input logic se, input logic [3:0] op,
                         input logic c, input logic z);
        @(posedge CLK);
        #1;
        RESET          = rst;
        bus_if.STEP_EN = se;
        bus_if.IR_OP   = op;
        bus_if.FLAG_C  = c;
        bus_if.FLAG_Z  = z;
        @(negedge CLK);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        int          n;      // execute steps
        logic [12:0] e2;
        logic [12:0] e3;
        logic [12:0] e4;
        logic        halts;
    } vec_t;

    vec_t vecs[14];

    int          mpos;
    logic        mh;
    logic [3:0]  op_cur;
    logic        r_rst, r_se, r_c, r_z;
    logic [12:0] ew;
    logic [12:0] ex;

    initial begin
        RESET = 1'b1;
        bus_if.STEP_EN = 1'b0;
        bus_if.IR_OP = 4'd0;
        bus_if.FLAG_C = 1'b0;
        bus_if.FLAG_Z = 1'b0;

        vecs[0]  = '{op:4'd0,  fc:1'b0, fz:1'b0, n:1, e2:IDLE, e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[1]  = '{op:4'd1,  fc:1'b0, fz:1'b0, n:2, e2:w(S_MI,3'd3), e3:w(S_AI,3'd2), e4:IDLE, halts:1'b0};
        vecs[2]  = '{op:4'd2,  fc:1'b1, fz:1'b0, n:3, e2:w(S_MI,3'd3), e3:w(S_BI,3'd2), e4:w(S_AI|S_FI,3'd5), halts:1'b0};
        vecs[3]  = '{op:4'd3,  fc:1'b0, fz:1'b1, n:3, e2:w(S_MI,3'd3), e3:w(S_BI,3'd2), e4:w(S_AI|S_FI|S_SU,3'd5), halts:1'b0};
        vecs[4]  = '{op:4'd4,  fc:1'b0, fz:1'b0, n:2, e2:w(S_MI,3'd3), e3:w(S_RI,3'd4), e4:IDLE, halts:1'b0};
        vecs[5]  = '{op:4'd5,  fc:1'b0, fz:1'b0, n:1, e2:w(S_AI,3'd3), e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[6]  = '{op:4'd6,  fc:1'b0, fz:1'b0, n:1, e2:w(S_J,3'd3), e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[7]  = '{op:4'd7,  fc:1'b0, fz:1'b1, n:1, e2:IDLE, e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[8]  = '{op:4'd7,  fc:1'b1, fz:1'b0, n:1, e2:w(S_J,3'd3), e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[9]  = '{op:4'd8,  fc:1'b1, fz:1'b0, n:1, e2:IDLE, e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[10] = '{op:4'd8,  fc:1'b0, fz:1'b1, n:1, e2:w(S_J,3'd3), e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[11] = '{op:4'd14, fc:1'b0, fz:1'b0, n:1, e2:w(S_OI,3'd4), e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[12] = '{op:4'd11, fc:1'b1, fz:1'b1, n:1, e2:IDLE, e3:IDLE, e4:IDLE, halts:1'b0};
        vecs[13] = '{op:4'd15, fc:1'b0, fz:1'b0, n:1, e2:IDLE, e3:IDLE, e4:IDLE, halts:1'b1};

        // Reset held two clocks, then fetch starts.
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("reset1_outputs", {19'd0, obs}, {19'd0, IDLE});
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("reset2_outputs", {19'd0, obs}, {19'd0, IDLE});
        chk("reset2_tstate", {29'd0, bus_if.TSTATE}, 32'd0);
        chk("reset2_halted", {31'd0, bus_if.HALTED}, 32'd0);
        drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        chk("release_t0", {19'd0, obs}, {19'd0, w(S_MI, 3'd1)});

        // One full instruction per table entry.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, vecs[i].op, vecs[i].fc, vecs[i].fz);
            drive(1'b0, 1'b1, vecs[i].op, vecs[i].fc, vecs[i].fz);
            chk($sformatf("v%0d_t0", i), {19'd0, obs}, {19'd0, w(S_MI, 3'd1)});
            drive(1'b0, 1'b1, vecs[i].op, vecs[i].fc, vecs[i].fz);
            chk($sformatf("v%0d_t1", i), {19'd0, obs}, {19'd0, w(S_II | S_CE, 3'd2)});
            for (int k = 0; k < vecs[i].n; k++) begin
                drive(1'b0, 1'b1, vecs[i].op, vecs[i].fc, vecs[i].fz);
                ex = (k == 0) ? vecs[i].e2 : ((k == 1) ? vecs[i].e3 : vecs[i].e4);
                chk($sformatf("v%0d_exec%0d", i, k), {19'd0, obs}, {19'd0, ex});
                chk($sformatf("v%0d_ts%0d", i, k), {29'd0, bus_if.TSTATE}, k + 2);
            end
            drive(1'b0, 1'b0, vecs[i].op, vecs[i].fc, vecs[i].fz);
            chk($sformatf("v%0d_end_ts", i), {29'd0, bus_if.TSTATE}, 32'd0);
            chk($sformatf("v%0d_end_halt", i), {31'd0, bus_if.HALTED}, {31'd0, vecs[i].halts});
        end

        // HLT: stays halted with no strobes for 10 clocks, reset recovers.
        drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
            chk("halt_hold_outputs", {19'd0, obs}, {19'd0, IDLE});
            chk("halt_hold_flag", {31'd0, bus_if.HALTED}, 32'd1);
        end
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("halt_reset_flag", {31'd0, bus_if.HALTED}, 32'd0);
        chk("halt_reset_fetch", {19'd0, obs}, {19'd0, w(S_MI, 3'd1)});

        // LDA paused three clocks at T3.
        drive(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
            chk("pause_ts", {29'd0, bus_if.TSTATE}, 32'd3);
            chk("pause_word", {19'd0, obs}, {19'd0, IDLE[12:3], 3'd2});
        end
        drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("resume_word", {19'd0, obs}, {19'd0, w(S_AI, 3'd2)});
        drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("resume_next_ts", {29'd0, bus_if.TSTATE}, 32'd0);

        // STA aborted by reset at T3.
        drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
        chk("abort_ts", {29'd0, bus_if.TSTATE}, 32'd3);
        chk("abort_word", {19'd0, obs}, {19'd0, IDLE});
        drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        chk("abort_next_ts", {29'd0, bus_if.TSTATE}, 32'd0);
        chk("abort_next_word", {19'd0, obs}, {19'd0, w(S_MI, 3'd1)});

        // Randomized run against the step-list model.
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        mpos = 0;
        mh = 1'b0;
        op_cur = 4'd0;
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 39) == 0);
            r_se  = ($urandom_range(0, 3) != 0);
            if (mpos == 0) op_cur = 4'($urandom_range(0, 15));
            r_c = 1'($urandom_range(0, 1));
            r_z = 1'($urandom_range(0, 1));
            drive(r_rst, r_se, op_cur, r_c, r_z);
            if (r_rst || mh) begin
                ew = IDLE;
            end else begin
                ew = mword(op_cur, r_c, r_z, mpos);
                if (!r_se) ew = {IDLE[12:3], ew[2:0]};
            end
            chk("rand_word", {19'd0, obs}, {19'd0, ew});
            chk("rand_ts", {29'd0, bus_if.TSTATE}, mpos);
            chk("rand_halted", {31'd0, bus_if.HALTED}, {31'd0, mh});
            if (r_rst) begin
                mpos = 0;
                mh = 1'b0;
            end else if (!mh && r_se) begin
                if (mpos == mlen(op_cur) - 1) begin
                    mpos = 0;
                    mh = (op_cur == 4'd15);
                end else begin
                    mpos = mpos + 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
